// File: rtl/muldiv_unit.sv
// Iterative RV32 M-extension unit: radix-2 shift-add multiplier and restoring divider
// sharing one 2*XLEN accumulator; the result is returned over a valid/ready handshake.
module muldiv_unit #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       op,
  input  logic [XLEN-1:0]  rs1_val,
  input  logic [XLEN-1:0]  rs2_val,
  input  logic [TAG_W-1:0] rd_in,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  result,
  output logic [TAG_W-1:0] rd_out
);

  localparam int unsigned CntW = $clog2(XLEN + 1);
  localparam logic [CntW-1:0] LastCnt = CntW'(XLEN - 1);

  typedef enum logic [1:0] {StIdle, StIter, StFix, StDone} state_e;

  state_e              state_q, state_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic [7:0]          op_q, op_d;
  logic [TAG_W-1:0]    rd_q, rd_d;
  logic [XLEN-1:0]     opnd_q, opnd_d;
  logic [2*XLEN-1:0]   acc_q, acc_d;
  logic [XLEN-1:0]     result_q, result_d;
  logic                neg_a_q, neg_a_d, neg_b_q, neg_b_d;
  logic                special_q, special_d;

  logic                op_onehot, accept, signed_a, signed_b, div0, ovf, special, is_mul_in;
  logic [XLEN-1:0]     mag_a, mag_b, quot, rem, quot_fix, rem_fix, res_fix;
  logic [XLEN:0]       mul_sum, div_trial;
  logic [2*XLEN-1:0]   mul_next, div_next, prod_fix;

  assign op_onehot = (op != 8'd0) && ((op & (op - 8'd1)) == 8'd0);
  assign accept    = in_valid && in_ready && op_onehot && !flush;
  assign signed_a  = op[0] | op[1] | op[2] | op[4] | op[6];
  assign signed_b  = op[0] | op[1] | op[4] | op[6];
  assign is_mul_in = |op[3:0];
  assign mag_a     = (signed_a && rs1_val[XLEN-1]) ? -rs1_val : rs1_val;
  assign mag_b     = (signed_b && rs2_val[XLEN-1]) ? -rs2_val : rs2_val;
  assign div0      = (|op[7:4]) && (rs2_val == '0);
  assign ovf       = (op[4] | op[6]) && (rs1_val == {1'b1, {(XLEN-1){1'b0}}}) &&
                     (rs2_val == {XLEN{1'b1}});
  assign special   = div0 || ovf;

  // Multiply: accumulate into the upper half, shift the multiplier out of the lower half.
  assign mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + {1'b0, (acc_q[0] ? opnd_q : {XLEN{1'b0}})};
  assign mul_next = {mul_sum, acc_q[XLEN-1:1]};
  // Divide: {remainder, quotient} shifts left; bit XLEN of the trial is the borrow.
  assign div_trial = acc_q[2*XLEN-1:XLEN-1] - {1'b0, opnd_q};
  assign div_next  = div_trial[XLEN] ? {acc_q[2*XLEN-2:0], 1'b0}
                                     : {div_trial[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};

  assign prod_fix = (neg_a_q ^ neg_b_q) ? -acc_q : acc_q;
  assign quot     = acc_q[XLEN-1:0];
  assign rem      = acc_q[2*XLEN-1:XLEN];
  assign quot_fix = (!special_q && (neg_a_q ^ neg_b_q)) ? -quot : quot;
  assign rem_fix  = (!special_q && neg_a_q) ? -rem : rem;

  always_comb begin
    res_fix = rem_fix;
    if (op_q[0])             res_fix = prod_fix[XLEN-1:0];
    else if (|op_q[3:1])     res_fix = prod_fix[2*XLEN-1:XLEN];
    else if (op_q[4] | op_q[5]) res_fix = quot_fix;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= StIdle;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (accept) state_d = special ? StFix : StIter;
      StIter:  if (cnt_q == LastCnt) state_d = StFix;
      StFix:   state_d = StDone;
      StDone:  if (out_ready) state_d = StIdle;
      default: state_d = StIdle;
    endcase
    if (flush) state_d = StIdle;
  end

  always_comb begin
    in_ready  = (state_q == StIdle);
    out_valid = (state_q == StDone);
  end

  always_comb begin
    cnt_d     = cnt_q;
    op_d      = op_q;
    rd_d      = rd_q;
    opnd_d    = opnd_q;
    acc_d     = acc_q;
    result_d  = result_q;
    neg_a_d   = neg_a_q;
    neg_b_d   = neg_b_q;
    special_d = special_q;
    if (accept) begin
      cnt_d     = '0;
      op_d      = op;
      rd_d      = rd_in;
      neg_a_d   = signed_a && rs1_val[XLEN-1];
      neg_b_d   = signed_b && rs2_val[XLEN-1];
      special_d = special;
      if (div0) begin
        acc_d = {rs1_val, {XLEN{1'b1}}};
      end else if (ovf) begin
        acc_d = {{XLEN{1'b0}}, 1'b1, {(XLEN-1){1'b0}}};
      end else if (is_mul_in) begin
        acc_d  = {{XLEN{1'b0}}, mag_b};
        opnd_d = mag_a;
      end else begin
        acc_d  = {{XLEN{1'b0}}, mag_a};
        opnd_d = mag_b;
      end
    end else if (state_q == StIter) begin
      cnt_d = cnt_q + CntW'(1);
      acc_d = (|op_q[3:0]) ? mul_next : div_next;
    end else if (state_q == StFix && !flush) begin
      result_d = res_fix;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      op_q      <= '0;
      rd_q      <= '0;
      opnd_q    <= '0;
      acc_q     <= '0;
      result_q  <= '0;
      neg_a_q   <= 1'b0;
      neg_b_q   <= 1'b0;
      special_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      op_q      <= op_d;
      rd_q      <= rd_d;
      opnd_q    <= opnd_d;
      acc_q     <= acc_d;
      result_q  <= result_d;
      neg_a_q   <= neg_a_d;
      neg_b_q   <= neg_b_d;
      special_q <= special_d;
    end
  end

  assign result = result_q;
  assign rd_out = rd_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: arithmetic results, latency, backpressure, flush, reset, bad ops.
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, flush, out_valid, out_ready;
  logic [7:0]  op;
  logic [31:0] rs1_val, rs2_val, result;
  logic [4:0]  rd_in, rd_out;

  int checks = 0;
  int errors = 0;

  muldiv_unit #(.XLEN(32), .TAG_W(5)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .op(op),
    .rs1_val(rs1_val), .rs2_val(rs2_val), .rd_in(rd_in), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .result(result), .rd_out(rd_out)
  );

  always #5 clk = ~clk;

  localparam logic [7:0] OpMul = 8'h01, OpMulh = 8'h02, OpMulhsu = 8'h04, OpMulhu = 8'h08;
  localparam logic [7:0] OpDiv = 8'h10, OpDivu = 8'h20, OpRem = 8'h40, OpRemu = 8'h80;

  // Issues one op, counts edges after accept until out_valid (bounded), then handshakes.
  task automatic run_op(input logic [7:0] o, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, output logic [31:0] res, output logic [4:0] rdo,
                        output int lat, output bit rdy_seen);
    @(posedge clk); #1;
    in_valid = 1'b1; op = o; rs1_val = a; rs2_val = b; rd_in = rd;
    @(posedge clk); #1;
    in_valid = 1'b0; lat = 0; rdy_seen = 1'b0;
    while (!out_valid && lat < 100) begin
      if (in_ready) rdy_seen = 1'b1;
      @(posedge clk); #1;
      lat++;
    end
    res = result; rdo = rd_out;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    checks++; if (result !== 32'h0) begin errors++; $display("FAIL reset_result got %h want 0", result); end
    checks++; if (rd_out !== 5'h0) begin errors++; $display("FAIL reset_rd_out got %h want 0", rd_out); end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
  endtask

  task automatic test_mul();
    logic [7:0]  ops [4] = '{OpMul, OpMulh, OpMulhu, OpMulhsu};
    logic [31:0] as  [4] = '{32'd7, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    logic [31:0] bs  [4] = '{32'hFFFF_FFFD, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    logic [31:0] exp [4] = '{32'hFFFF_FFEB, 32'h4000_0000, 32'hFFFF_FFFE, 32'hFFFF_FFFF};
    logic [31:0] res;
    logic [4:0]  rdo;
    int          lat;
    bit          rdy;
    for (int i = 0; i < 4; i++) begin
      run_op(ops[i], as[i], bs[i], 5'(i + 5), res, rdo, lat, rdy);
      checks++; if (res !== exp[i]) begin errors++; $display("FAIL mul_result[%0d] got %h want %h", i, res, exp[i]); end
      checks++; if (rdo !== 5'(i + 5)) begin errors++; $display("FAIL mul_rd[%0d] got %0d want %0d", i, rdo, i + 5); end
      checks++; if (lat !== 33) begin errors++; $display("FAIL mul_latency[%0d] got %0d want 33", i, lat); end
      checks++; if (rdy !== 1'b0) begin errors++; $display("FAIL mul_in_ready_busy[%0d] got %b want 0", i, rdy); end
    end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL mul_in_ready_after got %b want 1", in_ready); end
  endtask

  task automatic test_div();
    logic [7:0]  ops [8] = '{OpDiv, OpRem, OpDivu, OpRemu, OpDiv, OpRemu, OpDiv, OpRem};
    logic [31:0] as  [8] = '{32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'hFFFF_FFF9,
                             32'd5, 32'd5, 32'h8000_0000, 32'h8000_0000};
    logic [31:0] bs  [8] = '{32'd2, 32'd2, 32'd2, 32'd2, 32'd0, 32'd0,
                             32'hFFFF_FFFF, 32'hFFFF_FFFF};
    logic [31:0] exp [8] = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'h7FFF_FFFC, 32'd1,
                             32'hFFFF_FFFF, 32'd5, 32'h8000_0000, 32'd0};
    int          elat [8] = '{33, 33, 33, 33, 1, 1, 1, 1};
    logic [31:0] res;
    logic [4:0]  rdo;
    int          lat;
    bit          rdy;
    for (int i = 0; i < 8; i++) begin
      run_op(ops[i], as[i], bs[i], 5'(20 + i), res, rdo, lat, rdy);
      checks++; if (res !== exp[i]) begin errors++; $display("FAIL div_result[%0d] got %h want %h", i, res, exp[i]); end
      checks++; if (lat !== elat[i]) begin errors++; $display("FAIL div_latency[%0d] got %0d want %0d", i, lat, elat[i]); end
      checks++; if (rdo !== 5'(20 + i)) begin errors++; $display("FAIL div_rd[%0d] got %0d want %0d", i, rdo, 20 + i); end
    end
  endtask

  task automatic test_backpressure();
    int wait_cnt = 0;
    @(posedge clk); #1;
    in_valid = 1'b1; op = OpMul; rs1_val = 32'd6; rs2_val = 32'd9; rd_in = 5'd17;
    @(posedge clk); #1;
    in_valid = 1'b0;
    while (!out_valid && wait_cnt < 100) begin @(posedge clk); #1; wait_cnt++; end
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_out_valid got %b want 1", out_valid); end
    // A competing request while the result is stalled must be ignored.
    in_valid = 1'b1; op = OpDivu; rs1_val = 32'd100; rs2_val = 32'd3; rd_in = 5'd3;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b1 || result !== 32'd54 || rd_out !== 5'd17 || in_ready !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold[%0d] got v=%b r=%h rd=%0d rdy=%b want v=1 r=36 rd=17 rdy=0",
                 i, out_valid, result, rd_out, in_ready);
      end
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_in_ready_after got %b want 1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_out_valid_after got %b want 0", out_valid); end
  endtask

  task automatic test_flush();
    bit seen = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b1; op = OpDivu; rs1_val = 32'd100; rs2_val = 32'd7; rd_in = 5'd9;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    flush = 1'b1; in_valid = 1'b1; op = OpMul; rs1_val = 32'd2; rs2_val = 32'd3;
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL flush_idle got in_ready=%b want 1", in_ready); end
    for (int i = 0; i < 40; i++) begin
      if (out_valid) seen = 1'b1;
      @(posedge clk); #1;
    end
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL flush_no_output got %b want 0", seen); end
  endtask

  task automatic test_reset_mid();
    bit seen = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b1; op = OpMulhu; rs1_val = 32'h1234_5678; rs2_val = 32'h9ABC_DEF0; rd_in = 5'd30;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || result !== 32'h0 || rd_out !== 5'h0) begin
      errors++;
      $display("FAIL reset_mid got v=%b r=%h rd=%0d want all 0", out_valid, result, rd_out);
    end
    @(posedge clk); #1 rst_n = 1'b1;
    for (int i = 0; i < 40; i++) begin
      if (out_valid) seen = 1'b1;
      @(posedge clk); #1;
    end
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL reset_mid_no_output got %b want 0", seen); end
  endtask

  task automatic test_bad_op();
    bit seen = 1'b0;
    bit busy = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b1; op = 8'h03; rs1_val = 32'd4; rs2_val = 32'd5; rd_in = 5'd1;
    @(posedge clk); #1;
    op = 8'h00;
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (out_valid) seen = 1'b1;
      if (!in_ready) busy = 1'b1;
      @(posedge clk); #1;
    end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL bad_op_in_ready got busy=%b want 0", busy); end
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL bad_op_no_output got %b want 0", seen); end
  endtask

  initial begin
    in_valid = 1'b0; op = 8'h0; rs1_val = '0; rs2_val = '0; rd_in = '0;
    flush = 1'b0; out_ready = 1'b0;
    test_reset();
    test_mul();
    test_div();
    test_backpressure();
    test_flush();
    test_reset_mid();
    test_bad_op();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
